// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO sequencer bus: operation request from EX, stall and
// register-file write port back towards HI/LO.
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  // Handshake: start/op/a/b form a request that is consumed only while the
  // sequencer is idle (busy=0); there is no separate ready, busy=1 is the
  // back-pressure and any start seen while busy or writing is dropped.
  // hilo_we/done are single-cycle pulses; write data holds between pulses.
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic [1:0]       hilo_we;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;
  logic             done;

  modport master (
    output start, op, a, b, flush,
    input  busy, hilo_we, hi_wdata, lo_wdata, done
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, hilo_we, hi_wdata, lo_wdata, done
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative radix-2 multiply / restoring divide sequencer; sole writer of
// the HI/LO pair, with MTHI/MTLO pass-through and flush abort.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  hilo_muldiv_ctrl_if.slave bus,
  output logic [1:0]        dbg_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIX   = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state, state_n;

  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0]   opnd, opnd_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               neg_q, neg_q_n;
  logic               neg_r, neg_r_n;
  logic               is_div, is_div_n;

  logic               busy_q, busy_n;
  logic [1:0]         we_q, we_n;
  logic               done_q, done_n;
  logic [WIDTH-1:0]   hi_q, hi_n;
  logic [WIDTH-1:0]   lo_q, lo_n;

  logic               op_signed, op_div, op_arith;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Datapath: operand decode, one iteration step and the sign fix-up.
  always_comb begin
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    op_arith  = op_signed || (bus.op == OP_MULTU) || (bus.op == OP_DIVU);
    abs_a     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    addend   = acc[0] ? opnd : {WIDTH{1'b0}};
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend shifting into quotient}.
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opnd};
    div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

    if (is_div) begin
      fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo = neg_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
    end else begin
      {fix_hi, fix_lo} = neg_q ? -acc : acc;
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    opnd_n   = opnd;
    cnt_n    = cnt;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    is_div_n = is_div;
    busy_n   = 1'b0;
    we_n     = 2'b00;
    done_n   = 1'b0;
    hi_n     = hi_q;
    lo_n     = lo_q;

    case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (op_arith) begin
            cnt_n    = '0;
            is_div_n = op_div;
            busy_n   = 1'b1;
            if (op_div && (bus.b == '0)) begin
              // Divide by zero: raw dividend to HI, all-ones to LO, no fix-up.
              acc_n   = {bus.a, {WIDTH{1'b1}}};
              opnd_n  = '0;
              neg_q_n = 1'b0;
              neg_r_n = 1'b0;
              state_n = FIX;
            end else if (op_div) begin
              acc_n   = {{WIDTH{1'b0}}, abs_a};
              opnd_n  = abs_b;
              neg_q_n = op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_r_n = op_signed && bus.a[WIDTH-1];
              state_n = CALC;
            end else begin
              acc_n   = {{WIDTH{1'b0}}, abs_b};
              opnd_n  = abs_a;
              neg_q_n = op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_r_n = 1'b0;
              state_n = CALC;
            end
          end else if (bus.op == OP_MTHI) begin
            we_n   = 2'b10;
            hi_n   = bus.a;
            done_n = 1'b1;
          end else if (bus.op == OP_MTLO) begin
            we_n   = 2'b01;
            lo_n   = bus.a;
            done_n = 1'b1;
          end
        end
      end

      CALC: begin
        if (bus.flush) begin
          state_n = IDLE;
        end else begin
          busy_n = 1'b1;
          acc_n  = is_div ? div_step : mul_step;
          cnt_n  = cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state_n = FIX;
        end
      end

      FIX: begin
        if (bus.flush) begin
          state_n = IDLE;
        end else begin
          acc_n   = {fix_hi, fix_lo};
          hi_n    = fix_hi;
          lo_n    = fix_lo;
          we_n    = 2'b11;
          done_n  = 1'b1;
          state_n = WRITE;
        end
      end

      WRITE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      busy_q <= 1'b0;
      we_q   <= 2'b00;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      acc    <= acc_n;
      opnd   <= opnd_n;
      cnt    <= cnt_n;
      neg_q  <= neg_q_n;
      neg_r  <= neg_r_n;
      is_div <= is_div_n;
      busy_q <= busy_n;
      we_q   <= we_n;
      done_q <= done_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.hilo_we  = we_q;
  assign bus.done     = done_q;
  assign bus.hi_wdata = hi_q;
  assign bus.lo_wdata = lo_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: vector table for latency/results,
// then hand-written flush, reset and protocol-violation sequences.
module tb_hilo_muldiv_ctrl;
  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   we;
    int           lat;
    int           bsy;
  } vec_t;

  localparam int NV = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] hi_c, lo_c;
  logic [1:0]   we_c;
  logic         dn_c;
  int           lat_c, bsy_c, pulses;
  vec_t         vecs [NV];

  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if #(.WIDTH(W)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] hi, input logic [W-1:0] lo,
                              input logic [1:0] we, input int lat, input int bsy);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.we = we; v.lat = lat; v.bsy = bsy;
    return v;
  endfunction

  // Issues one request and follows it until the first HI/LO write pulse.
  // lat counts cycles after the start cycle; 0 means no write within budget.
  task automatic run_vec(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b000;
    lat_c = 0; bsy_c = 0; we_c = 2'b00; hi_c = '0; lo_c = '0; dn_c = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (bus.busy) bsy_c++;
      if (bus.hilo_we != 2'b00) begin
        lat_c = k; we_c = bus.hilo_we; hi_c = bus.hi_wdata; lo_c = bus.lo_wdata; dn_c = bus.done;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_pulses(input int ncyc);
    pulses = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (bus.hilo_we != 2'b00) pulses++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0; bus.flush = 1'b0;

    vecs[0]  = mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2'b11, 34, 33);
    vecs[1]  = mk(OP_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 2'b11, 34, 33);
    vecs[2]  = mk(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 2'b11, 34, 33);
    vecs[3]  = mk(OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 2'b11, 2,  1);
    vecs[4]  = mk(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 2'b11, 34, 33);
    vecs[5]  = mk(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2'b11, 34, 33);
    vecs[6]  = mk(OP_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'h00000000, 2'b10, 1,  0);
    vecs[7]  = mk(OP_MTLO,  32'hCAFEF00D, 32'd0,        32'h12345678, 32'hCAFEF00D, 2'b01, 1,  0);
    vecs[8]  = mk(OP_MULTU, 32'd6,        32'd7,        32'h00000000, 32'd42,       2'b11, 34, 33);
    vecs[9]  = mk(OP_DIVU,  32'd1000,     32'd7,        32'd6,        32'd142,      2'b11, 34, 33);
    vecs[10] = mk(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 2'b11, 34, 33);
    vecs[11] = mk(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 2'b11, 34, 33);
    vecs[12] = mk(OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 2'b11, 2,  1);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_we", {62'd0, bus.hilo_we}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hi", {32'd0, bus.hi_wdata}, 64'd0);
    check("rst_lo", {32'd0, bus.lo_wdata}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", {63'd0, bus.busy}, 64'd0);

    // Table-driven operations
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_lat", i), 64'(lat_c), 64'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 64'(bsy_c), 64'(vecs[i].bsy));
      check($sformatf("v%0d_we", i), {62'd0, we_c}, {62'd0, vecs[i].we});
      check($sformatf("v%0d_hi", i), {32'd0, hi_c}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i), {32'd0, lo_c}, {32'd0, vecs[i].lo});
      check($sformatf("v%0d_done", i), {63'd0, dn_c}, 64'd1);
      @(negedge clk);
      check($sformatf("v%0d_we_pulse_end", i), {62'd0, bus.hilo_we}, 64'd0);
      check($sformatf("v%0d_done_pulse_end", i), {63'd0, bus.done}, 64'd0);
      check($sformatf("v%0d_busy_after", i), {63'd0, bus.busy}, 64'd0);
    end

    // Flush at CALC cycle 10 of a DIVU
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b000;
    repeat (10) @(negedge clk);
    check("flush_busy_before", {63'd0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy_next", {63'd0, bus.busy}, 64'd0);
    check("flush_we_next", {62'd0, bus.hilo_we}, 64'd0);
    count_pulses(40);
    check("flush_no_write", 64'(pulses), 64'd0);
    run_vec(OP_MULTU, 32'd6, 32'd7);
    check("post_flush_lat", 64'(lat_c), 64'd34);
    check("post_flush_hi", {32'd0, hi_c}, 64'd0);
    check("post_flush_lo", {32'd0, lo_c}, 64'd42);

    // Flush coincident with MTHI in IDLE drops it
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MTHI; bus.a = 32'h55AA55AA;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'b000;
    check("flush_mthi_we", {62'd0, bus.hilo_we}, 64'd0);
    check("flush_mthi_done", {63'd0, bus.done}, 64'd0);
    check("flush_mthi_hi_hold", {32'd0, bus.hi_wdata}, 64'd0);

    // Asynchronous reset between clock edges mid-CALC
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'hFFFFFFFF; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b000;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_we", {62'd0, bus.hilo_we}, 64'd0);
    check("arst_lo", {32'd0, bus.lo_wdata}, 64'd0);
    check("arst_state", {62'd0, dbg_state}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    count_pulses(40);
    check("arst_no_write", 64'(pulses), 64'd0);

    // Start held while busy, then start in WRITE: both ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd6; bus.b = 32'd7;
    @(negedge clk);
    lat_c = 0; hi_c = '0; lo_c = '0;
    for (int k = 1; k <= 100; k++) begin
      if (k <= 10) begin
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd100; bus.b = 32'd100;
      end else begin
        bus.start = 1'b0; bus.op = 3'b000;
      end
      if (bus.hilo_we != 2'b00) begin
        lat_c = k; hi_c = bus.hi_wdata; lo_c = bus.lo_wdata;
        break;
      end
      @(negedge clk);
    end
    check("busy_start_lat", 64'(lat_c), 64'd34);
    check("busy_start_hi", {32'd0, hi_c}, 64'd0);
    check("busy_start_lo", {32'd0, lo_c}, 64'd42);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b000;
    check("write_start_we", {62'd0, bus.hilo_we}, 64'd0);
    check("write_start_hi", {32'd0, bus.hi_wdata}, 64'd0);
    count_pulses(40);
    check("write_start_no_write", 64'(pulses), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the MIPS EX stage; sole writer of the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Holds the pipeline stall (`busy`) while an operation is in flight, then issues a one-cycle HI/LO write (`hilo_we`, `hi_wdata`, `lo_wdata`) to the HI/LO register.
- A flush from the exception path aborts the operation without writing.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  operation request, sampled only in IDLE
- op  input  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP)
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- b  input  WIDTH  rt operand (multiplier / divisor)
- flush  input  1  abort the in-flight operation; no HI/LO write
- busy  output  1  pipeline stall request
- hilo_we  output  2  {hi_we, lo_we}, single-cycle pulse
- hi_wdata  output  WIDTH  HI write data
- lo_wdata  output  WIDTH  LO write data
- done  output  1  one-cycle completion pulse; it also fires for MTHI/MTLO

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, hilo_we=00, done=0, hi_wdata=0, lo_wdata=0; counter and work registers cleared. Takes effect mid-operation with no write.
- All outputs are registered.
- States: IDLE, CALC, FIX, WRITE.
- IDLE:
  - start=1 with MULT/MULTU/DIV/DIVU: latch operands, go to CALC, busy=1 from the next cycle.
  - For signed ops, latch |a| and |b| plus the result signs (quotient sign = sa^sb, remainder sign = sa).
  - MTHI: next cycle hilo_we=10, hi_wdata=a, done=1; busy stays 0.
  - MTLO: next cycle hilo_we=01, lo_wdata=a, done=1; busy stays 0.
  - NOP/reserved: ignored.
- CALC: exactly WIDTH cycles, counter runs 0..WIDTH-1.
  - Multiply: 2*WIDTH-bit accumulator, shift-add one bit per cycle.
  - Divide: restoring shift-subtract one quotient bit per cycle.
- Divide by zero (b=0): CALC is skipped and the FSM goes directly to FIX. Result forced to hi=a (raw dividend), lo={WIDTH{1}}.
- FIX (1 cycle): apply two's-complement sign correction for MULT/DIV.
  - MULT: negate the full 2*WIDTH product if the signs differ.
  - DIV: negate the quotient per the quotient sign and the remainder per the dividend sign.
  - Unsigned ops pass through unchanged.
- WRITE (1 cycle):
  - hilo_we=11, hi_wdata=product[2W-1:W] or remainder, lo_wdata=product[W-1:0] or quotient; done=1.
  - busy is deasserted in this same cycle. Return to IDLE.
- Latency: start in cycle N gives hilo_we=11 in cycle N+WIDTH+2 (N+34 at WIDTH=32); busy is high for cycles N+1 .. N+WIDTH+1. Division by zero: hilo_we in cycle N+2.
- start while busy=1 (or in WRITE) is ignored; the pipeline is stalled, so this is a protocol violation with no effect.
- flush has priority over everything:
  - In CALC or FIX: next state IDLE, busy=0 next cycle, hilo_we=00, done=0.
  - flush coincident with start in IDLE: start is dropped, including MTHI/MTLO.
  - flush in WRITE: the write is already committed and still occurs.
- Overflow cases:
  - MIN_INT/-1 (DIV): quotient 0x80000000, remainder 0.
  - MIN_INT*MIN_INT (MULT): HI=0x40000000, LO=0.
  - No exceptions are raised.
- hi_wdata/lo_wdata hold their last value when hilo_we=00.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF: busy high 33 cycles, then hilo_we=11, hi=0xFFFFFFFE, lo=0x00000001, done=1 at N+34.
- MULT a=-7 (0xFFFFFFF9) b=3: hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7 b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100 b=0: hilo_we=11 at N+2, hi=100, lo=0xFFFFFFFF, busy high 1 cycle. DIV a=0x80000000 b=-1: lo=0x80000000, hi=0.
- MTHI a=0x12345678 in IDLE: next cycle hilo_we=10, hi_wdata=0x12345678, busy stays 0. MTLO: hilo_we=01.
- DIVU started, flush at CALC cycle 10: busy=0 next cycle, no hilo_we pulse ever. A following MULTU 6*7 then yields lo=42, hi=0.
- Drive rst=0 asynchronously mid-CALC (between clock edges): outputs clear immediately, no write. A start issued while busy=1 does not alter the in-flight result.
